line_trigger_ctrl: RTL

Sequences the external-trigger path of the io channel. Takes the already-polarity-corrected line inputs (line0 from the optocoupler, line2/line3 from GPIO). Each line is synchronised and glitch-filtered, one line is selected as trigger source, and the chosen edge is detected. It applies a programmable trigger delay, then emits a single-cycle trigger to the sensor-control logic, reporting triggers it had to drop.

---
 rtl/line_trigger_ctrl_pkg.sv | 24 ++
 rtl/line_trigger_ctrl_if.sv | 18 +
 rtl/line_trigger_ctrl_filter.sv | 55 +++++
 rtl/line_trigger_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/line_trigger_ctrl_pkg.sv
// Shared encodings for the io-channel trigger path.
package io_channel_pkg;

    localparam int unsigned NUM_LINES = 3;

    typedef enum logic [1:0] {
        SRC_LINE0 = 2'd0,
        SRC_LINE2 = 2'd1,
        SRC_LINE3 = 2'd2,
        SRC_NONE  = 2'd3
    } src_e;

    typedef enum logic {
        ACT_RISE = 1'b0,
        ACT_FALL = 1'b1
    } act_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_FIRE  = 2'd2
    } state_e;

endpackage

// File: rtl/line_trigger_ctrl_if.sv
// Trigger handshake between this block (master) and sensor control (slave).
interface line_trigger_ctrl_if;
    logic i_frame_busy;
    logic o_trigger;
    logic o_trigger_miss;

    modport master (
        input  i_frame_busy,
        output o_trigger,
        output o_trigger_miss
    );

    modport slave (
        output i_frame_busy,
        input  o_trigger,
        input  o_trigger_miss
    );
endinterface

// File: rtl/line_trigger_ctrl_filter.sv
// Two-flop synchroniser plus saturating glitch filter for one line.
module line_filter #(
    parameter int unsigned FILTER_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    line_in,
    input  logic [FILTER_WIDTH-1:0] filter_rise,
    input  logic [FILTER_WIDTH-1:0] filter_fall,
    output logic                    level
);

    logic                    sync1;
    logic                    sync2;
    logic [FILTER_WIDTH-1:0] cnt;
    logic [FILTER_WIDTH-1:0] n_sel_c;
    logic [FILTER_WIDTH-1:0] n_eff_c;
    logic [FILTER_WIDTH:0]   cnt_inc_c;
    logic                    hit_c;

    // Threshold for the pending transition; zero behaves as one.
    always_comb begin
        n_sel_c   = level ? filter_fall : filter_rise;
        n_eff_c   = (n_sel_c == '0) ? FILTER_WIDTH'(1) : n_sel_c;
        cnt_inc_c = {1'b0, cnt} + (FILTER_WIDTH + 1)'(1);
        hit_c     = (cnt_inc_c >= {1'b0, n_eff_c});
    end

    // Synchroniser chain for the asynchronous pin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= line_in;
            sync2 <= sync1;
        end
    end

    // Count cycles of disagreement; flip the level when the threshold is met.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (hit_c) begin
            level <= ~level;
            cnt   <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + FILTER_WIDTH'(1);
        end
    end

endmodule

// File: rtl/line_trigger_ctrl.sv
// External-trigger sequencer: filter lines, select edge, delay, fire.
module line_trigger_ctrl
    import io_channel_pkg::*;
#(
    parameter int unsigned FILTER_WIDTH = 16,
    parameter int unsigned DELAY_WIDTH  = 20
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_optocoupler_in,
    input  logic [1:0]              iv_gpio_in,
    input  logic                    i_trigger_mode,
    input  logic [1:0]              iv_trigger_source,
    input  logic                    i_trigger_activation,
    input  logic [FILTER_WIDTH-1:0] iv_filter_rise,
    input  logic [FILTER_WIDTH-1:0] iv_filter_fall,
    input  logic [DELAY_WIDTH-1:0]  iv_trigger_delay,
    output logic [NUM_LINES-1:0]    ov_line_status,
    line_trigger_ctrl_if.master     trig_bus
);

    logic [NUM_LINES-1:0]   line_raw_c;
    logic [NUM_LINES-1:0]   level;
    logic [NUM_LINES-1:0]   prev_level;
    logic [NUM_LINES-1:0]   pick_c;
    logic                   hit_c;
    logic                   edge_hit;

    src_e                   src_sh;
    act_e                   act_sh;
    logic [DELAY_WIDTH-1:0] delay_sh;

    state_e                 state;
    state_e                 state_nx;
    logic [DELAY_WIDTH-1:0] dly_cnt;
    logic [DELAY_WIDTH-1:0] cnt_nx;
    logic                   miss_pend;
    logic                   pend_nx;
    logic                   trig_nx;
    logic                   miss_nx;

    assign line_raw_c     = {iv_gpio_in[1], iv_gpio_in[0], i_optocoupler_in};
    assign ov_line_status = level;

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_filt
        line_filter #(.FILTER_WIDTH(FILTER_WIDTH)) u_filt (
            .clk         (clk),
            .reset_n     (reset_n),
            .line_in     (line_raw_c[g]),
            .filter_rise (iv_filter_rise),
            .filter_fall (iv_filter_fall),
            .level       (level[g])
        );
    end

    // Edge of the selected filtered line in the selected direction.
    always_comb begin
        pick_c = (act_sh == ACT_FALL) ? (prev_level & ~level) : (level & ~prev_level);
        hit_c  = 1'b0;
        case (src_sh)
            SRC_LINE0: hit_c = pick_c[0];
            SRC_LINE2: hit_c = pick_c[1];
            SRC_LINE3: hit_c = pick_c[2];
            default:   hit_c = 1'b0;
        endcase
    end

    // Previous levels, registered edge strobe, and config shadows (tracked only in IDLE).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_level <= '0;
            edge_hit   <= 1'b0;
            src_sh     <= SRC_LINE0;
            act_sh     <= ACT_RISE;
            delay_sh   <= '0;
        end else begin
            prev_level <= level;
            edge_hit   <= hit_c;
            if (state == ST_IDLE) begin
                src_sh   <= src_e'(iv_trigger_source);
                act_sh   <= act_e'(i_trigger_activation);
                delay_sh <= iv_trigger_delay;
            end
        end
    end

    // FSM state, delay counter and registered trigger/miss pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                   <= ST_IDLE;
            dly_cnt                 <= '0;
            miss_pend               <= 1'b0;
            trig_bus.o_trigger      <= 1'b0;
            trig_bus.o_trigger_miss <= 1'b0;
        end else begin
            state                   <= state_nx;
            dly_cnt                 <= cnt_nx;
            miss_pend               <= pend_nx;
            trig_bus.o_trigger      <= trig_nx;
            trig_bus.o_trigger_miss <= miss_nx;
        end
    end

    // Next state; a miss coinciding with the fire decision is deferred one cycle.
    always_comb begin
        state_nx = state;
        cnt_nx   = dly_cnt;
        pend_nx  = miss_pend;
        trig_nx  = 1'b0;
        miss_nx  = 1'b0;
        case (state)
            ST_IDLE: begin
                pend_nx = 1'b0;
                if (edge_hit && i_trigger_mode) begin
                    if (trig_bus.i_frame_busy) begin
                        miss_nx = 1'b1;
                    end else begin
                        state_nx = ST_DELAY;
                        cnt_nx   = delay_sh;
                    end
                end
            end
            ST_DELAY: begin
                if (!i_trigger_mode) begin
                    state_nx = ST_IDLE;
                    pend_nx  = 1'b0;
                end else if (dly_cnt == '0) begin
                    state_nx = ST_FIRE;
                    trig_nx  = 1'b1;
                    pend_nx  = edge_hit;
                end else begin
                    cnt_nx  = dly_cnt - DELAY_WIDTH'(1);
                    miss_nx = edge_hit;
                end
            end
            ST_FIRE: begin
                state_nx = ST_IDLE;
                miss_nx  = edge_hit | miss_pend;
                pend_nx  = 1'b0;
            end
            default: begin
                state_nx = ST_IDLE;
                pend_nx  = 1'b0;
            end
        endcase
    end

endmodule
